// File: rtl/latency_memory.sv
// Byte-maskable word memory with fixed response latency and a
// minimum spacing between accepted requests.
module latency_memory #(
  parameter int SIZE     = 1024,
  parameter int LATENCY  = 4,
  parameter int INTERVAL = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_ready,
  input  logic [31:0] i_addr,
  input  logic        i_ren,
  input  logic        i_wen,
  input  logic [3:0]  i_mask,
  input  logic [31:0] i_wdata,
  output logic        o_valid,
  output logic [31:0] o_rdata
);

  localparam int IW    = $clog2(SIZE);
  localparam int DEPTH = SIZE / 4;
  localparam int CW    = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

  logic [31:0] mem [0:DEPTH-1];

  logic [IW-3:0]      idx;
  logic               accept;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [31:0]        dat_q [LATENCY];
  logic [31:0]        dat_d [LATENCY];
  logic               valid_q, valid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               unused_addr;

  assign idx         = i_addr[IW-1:2];
  assign unused_addr = ^{i_addr[31:IW], i_addr[1:0]};
  assign o_ready     = (cnt_q == '0);
  assign accept      = o_ready & (i_ren | i_wen) & i_rst;
  assign o_valid     = valid_q;
  assign o_rdata     = rdata_q;

  always_comb begin
    cnt_d   = cnt_q;
    vld_d   = '0;
    valid_d = vld_q[LATENCY-1];
    rdata_d = rdata_q;
    if (accept) begin
      cnt_d = CW'(INTERVAL - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
    // stage 0 captures the pre-write word for reads and writes alike
    vld_d[0] = accept;
    dat_d[0] = mem[idx];
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
    if (vld_q[LATENCY-1]) begin
      rdata_d = dat_q[LATENCY-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cnt_q   <= '0;
      vld_q   <= '0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      for (int i = 0; i < LATENCY; i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  // storage is never reset so preloaded contents survive
  always_ff @(posedge i_clk) begin
    if (accept && i_wen) begin
      for (int b = 0; b < 4; b++) begin
        if (i_mask[b]) begin
          mem[idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_latency_memory.sv
// Bench for latency_memory: directed steps then random traffic,
// checked against a queue-based timing model.
module tb_latency_memory;

  localparam int SIZE     = 1024;
  localparam int LATENCY  = 4;
  localparam int INTERVAL = 2;
  localparam int WORDS    = SIZE / 4;

  logic        clk;
  logic        rst_n;
  logic        ready;
  logic [31:0] addr;
  logic        ren;
  logic        wen;
  logic [3:0]  mask;
  logic [31:0] wdata;
  logic        valid;
  logic [31:0] rdata;

  latency_memory #(
    .SIZE(SIZE), .LATENCY(LATENCY), .INTERVAL(INTERVAL)
  ) dut (
    .i_clk(clk), .i_rst(rst_n), .o_ready(ready),
    .i_addr(addr), .i_ren(ren), .i_wen(wen),
    .i_mask(mask), .i_wdata(wdata),
    .o_valid(valid), .o_rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  resp_t       q[$];
  logic [31:0] ref_mem [WORDS];
  int          cyc;
  int          ready_at;
  logic        exp_ready;
  logic        exp_valid;
  logic [31:0] exp_rdata;
  int          vectors;
  int          miscompares;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d",
             tag, obs, exp, cyc);
    end
  endtask

  // Model: a request is taken when no earlier acceptance lies within
  // INTERVAL cycles; its answer is due exactly LATENCY edges later.
  task automatic tick();
    int w;
    exp_valid = 1'b0;
    if (!rst_n) begin
      q.delete();
      ready_at  = cyc + 1;
      exp_rdata = '0;
    end else begin
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_valid = 1'b1;
        exp_rdata = q[0].data;
        void'(q.pop_front());
      end
      if (cyc >= ready_at && (ren || wen)) begin
        w = int'(addr[9:2]);
        q.push_back('{due: cyc + LATENCY, data: ref_mem[w]});
        if (wen) begin
          for (int b = 0; b < 4; b++) begin
            if (mask[b]) ref_mem[w][8*b +: 8] = wdata[8*b +: 8];
          end
        end
        ready_at = cyc + INTERVAL;
      end
    end
    exp_ready = (cyc + 1 >= ready_at);
    @(posedge clk);
    #1;
    chk("ready", {31'd0, ready}, {31'd0, exp_ready});
    chk("valid", {31'd0, valid}, {31'd0, exp_valid});
    chk("rdata", rdata, exp_rdata);
    cyc++;
  endtask

  task automatic idle(input int n);
    ren = 1'b0;
    wen = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic op(input logic r, input logic wr, input logic [31:0] a,
                    input logic [3:0] m, input logic [31:0] d);
    ren   = r;
    wen   = wr;
    addr  = a;
    mask  = m;
    wdata = d;
    tick();
    idle(INTERVAL - 1);
  endtask

  initial begin
    logic [31:0] v;
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    ready_at    = 0;
    exp_rdata   = '0;
    rst_n = 1'b0;
    ren   = 1'b1;
    wen   = 1'b0;
    addr  = '0;
    mask  = '0;
    wdata = '0;
    @(negedge clk);

    // reset with a pending read: nothing is accepted
    repeat (3) tick();
    rst_n = 1'b1;
    idle(2);

    // preload every word through full-mask writes
    for (int w = 0; w < WORDS; w++) begin
      if (w == 0)      v = 32'h0000_0013;
      else if (w == 1) v = 32'hDEAD_BEEF;
      else if (w == 2) v = 32'h1122_3344;
      else             v = $urandom;
      op(1'b0, 1'b1, 32'(w * 4), 4'hF, v);
    end
    idle(LATENCY + 1);

    // reset again with a request held: preload survives
    rst_n = 1'b0;
    ren   = 1'b1;
    addr  = 32'h0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst_rdata", rdata, 32'h0);
    op(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    idle(LATENCY);
    chk("mem0", rdata, 32'h0000_0013);

    // read latency
    op(1'b1, 1'b0, 32'h4, 4'h0, 32'h0);
    idle(LATENCY);
    chk("rd_lat", rdata, 32'hDEAD_BEEF);

    // masked write returns the old word, then read back
    op(1'b0, 1'b1, 32'h8, 4'b0110, 32'hAABB_CCDD);
    idle(LATENCY);
    chk("wr_old", rdata, 32'h1122_3344);
    op(1'b1, 1'b0, 32'h8, 4'h0, 32'h0);
    idle(LATENCY);
    chk("wr_mask", rdata, 32'h11BB_CC44);

    // read and write together: old word back, new word stored
    op(1'b1, 1'b1, 32'h8, 4'b1001, 32'h5566_7788);
    idle(LATENCY);
    chk("rw_old", rdata, 32'h11BB_CC44);
    op(1'b1, 1'b0, 32'h8, 4'h0, 32'h0);
    idle(LATENCY);
    chk("rw_new", rdata, 32'h55BB_CC88);

    // back-to-back reads held over six cycles
    ren = 1'b1;
    wen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      addr = (i % 2 == 0) ? 32'h0 : 32'h4;
      tick();
    end
    idle(LATENCY + 2);

    // address wrap
    op(1'b1, 1'b0, 32'h0000_0404, 4'h0, 32'h0);
    idle(LATENCY);
    chk("wrap404", rdata, 32'hDEAD_BEEF);
    op(1'b1, 1'b0, 32'h0000_0007, 4'h0, 32'h0);
    idle(LATENCY);
    chk("wrap007", rdata, 32'hDEAD_BEEF);

    // reset while a read is in flight
    op(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_ready", {31'd0, ready}, 32'd1);
    idle(LATENCY + 2);

    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      ren   = $urandom_range(0, 1);
      wen   = ($urandom_range(0, 3) == 0);
      addr  = $urandom;
      mask  = 4'($urandom);
      wdata = $urandom;
      tick();
    end
    rst_n = 1'b1;
    idle(LATENCY + 2);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
